// File: rtl/device_rfe_rec.sv
// Fuzzy-extractor key reconstruction: replays helper data against a noisy PUF read
// and decodes every 32-bit block with a serial RM(1,5) correlation decoder.
module device_rfe_rec #(
   parameter int PUF_BLOCKS  = 2,
   parameter int BLOCKS      = 22,
   parameter int PUF_TIMEOUT = 1024
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [BLOCKS*32-1:0]     helper_data,
   output logic                     puf_read_req,
   input  logic [PUF_BLOCKS*32-1:0] puf_data,
   input  logic                     puf_valid,
   output logic                     busy,
   output logic [BLOCKS*32-1:0]     rprime,
   output logic                     rprime_valid,
   output logic                     done,
   output logic [BLOCKS-1:0]        fail_mask,
   output logic                     timeout_err
);

   localparam int BW = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;
   localparam int PW = (PUF_BLOCKS > 1) ? $clog2(PUF_BLOCKS) : 1;
   localparam int TW = $clog2(PUF_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PUF_WAIT,
      S_SEARCH,
      S_COMMIT,
      S_DONE,
      S_ABORT
   } state_t;

   state_t state, state_nxt;

   logic [BLOCKS*32-1:0]     helper_q;
   logic [PUF_BLOCKS*32-1:0] puf_q;
   logic [BW-1:0]            blk;
   logic [PW-1:0]            widx;
   logic [4:0]               cand;
   logic [5:0]               best_dist;
   logic [4:0]               best_a;
   logic                     best_sign;
   logic [TW-1:0]            tmo_cnt;

   logic [31:0] blk_helper;
   logic [31:0] blk_word;
   logic [31:0] corr_word;
   logic [5:0]  d0;
   logic [5:0]  d1;
   logic        cand_sign;
   logic [5:0]  cand_dist;
   logic [31:0] codeword;
   logic        last_blk;
   logic        tmo_hit;

   // Linear part of the RM(1,5) codeword: bit j = parity(a & j).
   function automatic logic [31:0] lin_word(input logic [4:0] a);
      logic [31:0] r;
      r = '0;
      for (int unsigned j = 0; j < 32; j++) begin
         r[j] = ^(a & 5'(j));
      end
      return r;
   endfunction

   function automatic logic [5:0] popcount32(input logic [31:0] v);
      logic [5:0] c;
      c = '0;
      for (int unsigned j = 0; j < 32; j++) begin
         c = c + {5'd0, v[j]};
      end
      return c;
   endfunction

   assign blk_helper = helper_q[int'(blk)*32 +: 32];
   assign blk_word   = puf_q[int'(widx)*32 +: 32];
   assign corr_word  = blk_helper ^ blk_word ^ lin_word(cand);
   assign d0         = popcount32(corr_word);
   assign d1         = 6'd32 - d0;
   assign cand_sign  = (d1 < d0);
   assign cand_dist  = cand_sign ? d1 : d0;
   assign codeword   = {32{best_sign}} ^ lin_word(best_a);
   assign last_blk   = (blk == BW'(BLOCKS - 1));
   assign tmo_hit    = (tmo_cnt == TW'(PUF_TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:     if (start) state_nxt = S_PUF_WAIT;
         S_PUF_WAIT: begin
            if (puf_valid)    state_nxt = S_SEARCH;
            else if (tmo_hit) state_nxt = S_ABORT;
         end
         S_SEARCH:   if (cand == 5'd31) state_nxt = S_COMMIT;
         S_COMMIT:   state_nxt = last_blk ? S_DONE : S_SEARCH;
         S_DONE:     state_nxt = S_IDLE;
         S_ABORT:    state_nxt = S_IDLE;
         default:    state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy         = 1'b0;
      puf_read_req = 1'b0;
      done         = 1'b0;
      case (state)
         S_PUF_WAIT: begin
            busy         = 1'b1;
            puf_read_req = 1'b1;
         end
         S_SEARCH, S_COMMIT: busy = 1'b1;
         S_DONE, S_ABORT:    done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         helper_q     <= '0;
         puf_q        <= '0;
         blk          <= '0;
         widx         <= '0;
         cand         <= '0;
         best_dist    <= 6'd33;
         best_a       <= '0;
         best_sign    <= 1'b0;
         tmo_cnt      <= '0;
         rprime       <= '0;
         rprime_valid <= 1'b0;
         fail_mask    <= '0;
         timeout_err  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  helper_q     <= helper_data;
                  rprime_valid <= 1'b0;
                  fail_mask    <= '0;
                  timeout_err  <= 1'b0;
                  tmo_cnt      <= '0;
               end
            end
            S_PUF_WAIT: begin
               tmo_cnt <= tmo_cnt + TW'(1);
               if (puf_valid) begin
                  puf_q     <= puf_data;
                  blk       <= '0;
                  widx      <= '0;
                  cand      <= '0;
                  best_dist <= 6'd33;
                  best_a    <= '0;
                  best_sign <= 1'b0;
               end else if (tmo_hit) begin
                  timeout_err <= 1'b1;
               end
            end
            S_SEARCH: begin
               cand <= cand + 5'd1;
               // Strictly-smaller update keeps the lowest candidate on ties.
               if (cand_dist < best_dist) begin
                  best_dist <= cand_dist;
                  best_a    <= cand;
                  best_sign <= cand_sign;
               end
            end
            S_COMMIT: begin
               rprime[int'(blk)*32 +: 32] <= blk_helper ^ codeword;
               fail_mask[blk]             <= (best_dist > 6'd7);
               cand      <= '0;
               best_dist <= 6'd33;
               best_a    <= '0;
               best_sign <= 1'b0;
               if (last_blk) begin
                  rprime_valid <= 1'b1;
               end else begin
                  blk  <= blk + BW'(1);
                  widx <= (widx == PW'(PUF_BLOCKS - 1)) ? '0 : widx + PW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_device_rfe_rec.sv
// Scoreboard bench for device_rfe_rec: stimulus queues expected results, a monitor
// compares them whenever done pulses.
module tb_device_rfe_rec;

   localparam int PB = 2;
   localparam int NB = 22;
   localparam int PT = 1024;

   typedef logic [NB*32-1:0] wide_t;

   typedef struct {
      wide_t          rp;
      wide_t          rmask;
      logic [NB-1:0]  fm;
      logic           tmo;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [NB*32-1:0]  helper_data;
   logic              puf_read_req;
   logic [PB*32-1:0]  puf_data;
   logic              puf_valid;
   logic              busy;
   logic [NB*32-1:0]  rprime;
   logic              rprime_valid;
   logic              done;
   logic [NB-1:0]     fail_mask;
   logic              timeout_err;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   device_rfe_rec #(
      .PUF_BLOCKS (PB),
      .BLOCKS     (NB),
      .PUF_TIMEOUT(PT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .helper_data (helper_data),
      .puf_read_req(puf_read_req),
      .puf_data    (puf_data),
      .puf_valid   (puf_valid),
      .busy        (busy),
      .rprime      (rprime),
      .rprime_valid(rprime_valid),
      .done        (done),
      .fail_mask   (fail_mask),
      .timeout_err (timeout_err)
   );

   task automatic check(input string name, input wide_t act, input wide_t req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", name, act, req);
      end
   endtask

   // Enrollment-side encoder: bit j = m[5] ^ parity(m[4:0] & j).
   function automatic logic [31:0] cw(input logic [5:0] m);
      logic [31:0] r;
      logic [4:0]  jj;
      for (int j = 0; j < 32; j++) begin
         jj   = 5'(j);
         r[j] = m[5] ^ (^(m[4:0] & jj));
      end
      return r;
   endfunction

   function automatic wide_t rep(input logic [PB*32-1:0] p);
      wide_t r;
      for (int b = 0; b < NB; b++) r[b*32 +: 32] = p[(b % PB)*32 +: 32];
      return r;
   endfunction

   // mode 0: m_b = 0x2A + 7b, mode 1: m_b = 0x20, mode 2: y = 0x00FF0000 (tie)
   function automatic wide_t mk_helper(input logic [PB*32-1:0] p, input int mode);
      wide_t       h;
      logic [5:0]  m;
      logic [31:0] w;
      for (int b = 0; b < NB; b++) begin
         w = p[(b % PB)*32 +: 32];
         m = 6'((42 + 7*b) % 64);
         if (mode == 1) m = 6'h20;
         h[b*32 +: 32] = (mode == 2) ? (w ^ 32'h00FF_0000) : (w ^ cw(m));
      end
      return h;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (!reset && done) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1, want no pending result");
         end else begin
            e = exp_q.pop_front();
            if (e.rmask != '0) check("rprime", rprime & e.rmask, e.rp & e.rmask);
            check("fail_mask", wide_t'(fail_mask), wide_t'(e.fm));
            check("timeout_err", wide_t'(timeout_err), wide_t'(e.tmo));
            check("rprime_valid", wide_t'(rprime_valid), wide_t'(!e.tmo));
            check("busy_at_done", wide_t'(busy), '0);
         end
      end
   end

   task automatic run(input wide_t h, input logic [PB*32-1:0] p, input exp_t e,
                      input bit disturb, input int vdelay);
      int cyc;
      exp_q.push_back(e);
      @(negedge clk);
      helper_data = h;
      start       = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("req_after_start", wide_t'({puf_read_req, busy, rprime_valid}), wide_t'(3'b110));
      repeat (vdelay) @(negedge clk);
      puf_data  = p;
      puf_valid = 1'b1;
      @(negedge clk);
      puf_valid = 1'b0;
      cyc       = 1;
      check("req_dropped", wide_t'(puf_read_req), '0);
      while (!done && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         start = disturb && (cyc == 10);
      end
      start = 1'b0;
      check("latency", wide_t'(cyc), wide_t'(727));
   endtask

   localparam logic [63:0] PUF = 64'h0123_4567_89AB_CDEF;

   initial begin
      exp_t  e;
      wide_t h0, ht;
      int    cyc;

      reset       = 1'b1;
      start       = 1'b0;
      puf_valid   = 1'b0;
      puf_data    = '0;
      helper_data = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("reset_ctrl", wide_t'({busy, done, rprime_valid, puf_read_req, timeout_err, fail_mask}), '0);
      check("reset_rprime", rprime, '0);

      h0      = mk_helper(PUF, 0);
      e.rp    = rep(PUF);
      e.rmask = '1;
      e.fm    = '0;
      e.tmo   = 1'b0;

      run(h0, PUF, e, 1'b0, 3);
      @(negedge clk);
      check("valid_held", wide_t'(rprime_valid), wide_t'(1));
      run(h0, PUF ^ 64'h7F, e, 1'b0, 0);

      // 9 flipped bits spanning 0 and every unit vector: uncorrectable on word 0 blocks
      e.rmask = '0;
      for (int b = 1; b < NB; b += 2) e.rmask[b*32 +: 32] = '1;
      e.fm    = 22'h155555;
      run(h0, PUF ^ 64'h0001_017F, e, 1'b0, 5);

      e.rmask = '1;
      e.fm    = '0;
      run(mk_helper(PUF, 1), PUF, e, 1'b0, 1);

      // Many candidates tie at distance 8; a=0 with sign 0 must win -> rprime = helper
      ht   = mk_helper(PUF, 2);
      e.rp = ht;
      e.fm = '1;
      run(ht, PUF, e, 1'b0, 2);

      e.rp = rep(PUF);
      e.fm = '0;
      run(h0, PUF, e, 1'b1, 0);

      // Timeout: puf_valid never arrives
      e.rmask = '0;
      e.rp    = '0;
      e.tmo   = 1'b1;
      exp_q.push_back(e);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("tmo_req", wide_t'(puf_read_req), wide_t'(1));
      cyc = 0;
      while (!done && cyc < 3000) begin
         @(negedge clk);
         cyc++;
      end
      check("tmo_latency", wide_t'(cyc), wide_t'(PT));
      @(negedge clk);
      check("tmo_after", wide_t'({puf_read_req, busy, timeout_err, rprime_valid}), wide_t'(4'b0010));

      // Reset in the middle of SEARCH
      @(negedge clk);
      helper_data = h0;
      start       = 1'b1;
      @(negedge clk);
      start     = 1'b0;
      puf_data  = PUF;
      puf_valid = 1'b1;
      @(negedge clk);
      puf_valid = 1'b0;
      repeat (40) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midreset_ctrl", wide_t'({busy, done, rprime_valid, puf_read_req, timeout_err, fail_mask}), '0);
      check("midreset_rprime", rprime, '0);

      e.rp    = rep(PUF);
      e.rmask = '1;
      e.fm    = '0;
      e.tmo   = 1'b0;
      run(h0, PUF ^ 64'h0000_0005_0000_0000, e, 1'b0, 0);

      repeat (3) @(negedge clk);
      check("queue_empty", wide_t'(exp_q.size()), '0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
